// File: rtl/instr_pkg.sv
// Shared encoding constants for the instruction encoder: op codes, S-field codes,
// special-op immediates, the 9-bit word layout and the FIFO depth.
package instr_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int ADDR_W     = 4;
    localparam int ERR_CNT_W  = 4;
    localparam int IMM_W      = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_ADD = 2'b00,
        S_SUB = 2'b01,
        S_AND = 2'b10,
        S_EXT = 2'b11
    } sfield_e;

    // Special ops share S_EXT with OR and are told apart by c=1 and a small immediate.
    localparam logic [IMM_W-1:0] IMM_XOR      = 4'b0001;
    localparam logic [IMM_W-1:0] IMM_NOT      = 4'b0000;
    localparam logic [IMM_W-1:0] IMM_SHL      = 4'b0010;
    localparam logic [IMM_W-1:0] IMM_SHR      = 4'b0011;
    localparam logic [IMM_W-1:0] OR_ALIAS_MAX = 4'd3;

    // Bit layout, MSB first: {c, LB, LA, S1, S0, imm[3:0]}.
    typedef struct packed {
        logic             c;
        logic             lb;
        logic             la;
        sfield_e          s;
        logic [IMM_W-1:0] imm;
    } word_t;

    localparam int WORD_W = $bits(word_t);

    function automatic word_t encode_word(
        input op_e              op,
        input logic             la,
        input logic             lb,
        input logic             imm_sel,
        input logic [IMM_W-1:0] imm
    );
        word_t w;
        w.c   = imm_sel;
        w.lb  = lb;
        w.la  = la;
        w.s   = S_EXT;
        w.imm = imm;
        case (op)
            OP_ADD:  w.s = S_ADD;
            OP_SUB:  w.s = S_SUB;
            OP_AND:  w.s = S_AND;
            OP_OR:   w.s = S_EXT;
            OP_XOR:  begin w.c = 1'b1; w.imm = IMM_XOR; end
            OP_NOT:  begin w.c = 1'b1; w.imm = IMM_NOT; end
            OP_SHL:  begin w.c = 1'b1; w.imm = IMM_SHL; end
            OP_SHR:  begin w.c = 1'b1; w.imm = IMM_SHR; end
            default: w.s = S_EXT;
        endcase
        return w;
    endfunction

    // An immediate OR with a small constant would decode as one of the special ops.
    function automatic logic is_or_alias(
        input op_e              op,
        input logic             imm_sel,
        input logic [IMM_W-1:0] imm
    );
        return (op == OP_OR) && imm_sel && (imm <= OR_ALIAS_MAX);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Count-based FIFO of encoded words; flush empties it and wins over push/pop.
// Read data is forced to zero while empty.
module instr_fifo
    import instr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  word_t            wdata_i,
    output word_t            rdata_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    word_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i && (count_q != CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: turns op requests into 9-bit control words queued for a sequencer.
// Optional OR-alias legality check is built in when INSTR_ENC_LEGAL_CHECK_EN is defined.
module instr_encoder
    import instr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic                 in_la,
    input  logic                 in_lb,
    input  logic                 in_imm_sel,
    input  logic [IMM_W-1:0]     in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_im,
    output logic [ADDR_W-1:0]    out_addr,
    input  logic                 flush,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and out_valid/out_im hold until the word is taken.

    word_t             enc_word;
    word_t             head_word;
    logic [CNT_W-1:0]  fifo_count;
    logic              push_fire;
    logic              pop_fire;
    logic              illegal;
    logic              fifo_push;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign enc_word  = encode_word(op_e'(in_op), in_la, in_lb, in_imm_sel, in_imm);
    // No bypass: a full FIFO refuses input even when a pop is in flight.
    assign in_ready  = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push_fire = in_valid && in_ready;
    assign pop_fire  = out_valid && out_ready;
    assign fifo_push = push_fire && !illegal && !flush;

    instr_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (pop_fire),
        .flush_i (flush),
        .wdata_i (enc_word),
        .rdata_o (head_word),
        .valid_o (out_valid),
        .count_o (fifo_count)
    );

    assign out_im = head_word;

    always_comb begin
        addr_d = addr_q;
        if (flush) begin
            addr_d = '0;
        end else if (pop_fire) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign out_addr = addr_q;

`ifdef INSTR_ENC_LEGAL_CHECK_EN
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign illegal = is_or_alias(op_e'(in_op), in_imm_sel, in_imm);

    // Illegal requests still complete the handshake; a flush swallows them silently.
    always_comb begin
        err_d     = push_fire && illegal && !flush;
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    assign illegal = 1'b0;
    assign err     = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against a queue-based reference model.
// Follows INSTR_ENC_LEGAL_CHECK_EN so either build of the design can be checked.
module tb_instr_encoder;

`ifdef INSTR_ENC_LEGAL_CHECK_EN
  localparam bit LEGAL_CHECK = 1'b1;
`else
  localparam bit LEGAL_CHECK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic       in_la;
  logic       in_lb;
  logic       in_imm_sel;
  logic [3:0] in_imm;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_im;
  logic [3:0] out_addr;
  logic       flush;
  logic       err;
  logic [3:0] err_cnt;

  instr_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_la      (in_la),
    .in_lb      (in_lb),
    .in_imm_sel (in_imm_sel),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_im     (out_im),
    .out_addr   (out_addr),
    .flush      (flush),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [8:0] exp_q[$];
  int         m_addr;
  int         m_err_cnt;
  int         m_err;
  int         spec_imm[4] = '{1, 0, 2, 3};

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [8:0] ref_word(input int op, input int la, input int lb,
                                          input int sel, input int imm);
    int s, c, v;
    if (op <= 2) begin
      s = op; c = sel; v = imm;
    end else if (op == 3) begin
      s = 3; c = sel; v = imm;
    end else begin
      s = 3; c = 1; v = spec_imm[op - 4];
    end
    return 9'(c * 256 + lb * 128 + la * 64 + s * 16 + v);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_addr    = 0;
    m_err     = 0;
    m_err_cnt = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_outputs();
    logic [8:0] head;
    head = 9'h0;
    if (exp_q.size() != 0) head = exp_q[0];
    check("out_valid", 16'(out_valid), 16'(exp_q.size() != 0));
    check("out_im",    16'(out_im),    16'(head));
    check("out_addr",  16'(out_addr),  16'(m_addr));
    check("in_ready",  16'(in_ready),  16'(exp_q.size() < 4));
    check("err",       16'(err),       16'(m_err));
    check("err_cnt",   16'(err_cnt),   16'(m_err_cnt));
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, advances the model across the clock edge, then checks.
  task automatic step(input logic v, input logic [2:0] op, input logic la, input logic lb,
                      input logic sel, input logic [3:0] imm, input logic ordy, input logic fl);
    bit push, pop, ill;
    in_valid   = v;
    in_op      = op;
    in_la      = la;
    in_lb      = lb;
    in_imm_sel = sel;
    in_imm     = imm;
    out_ready  = ordy;
    flush      = fl;
    push = v && (exp_q.size() < 4);
    pop  = (exp_q.size() != 0) && ordy;
    ill  = LEGAL_CHECK && (op == 3'd3) && sel && (imm <= 4'd3);
    @(posedge clk);
    #1;
    m_err = 0;
    if (fl) begin
      exp_q.delete();
      m_addr = 0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        m_addr = (m_addr + 1) % 16;
      end
      if (push && ill) begin
        m_err = 1;
        if (m_err_cnt < 15) m_err_cnt++;
      end else if (push) begin
        exp_q.push_back(ref_word(op, la, lb, sel, imm));
      end
    end
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, ordy, 1'b0);
  endtask

  task automatic rand_step();
    logic [2:0] op;
    logic [3:0] imm;
    op  = 3'($urandom_range(0, 7));
    imm = 4'($urandom_range(0, 15));
    if (op == 3'd3 && $urandom_range(0, 1) == 1) imm = 4'($urandom_range(0, 3));
    step(1'($urandom_range(0, 3) != 0), op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), imm, 1'($urandom_range(0, 2) != 0),
         1'($urandom_range(0, 31) == 0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_op = 3'd0; in_la = 1'b0; in_lb = 1'b0;
    in_imm_sel = 1'b0; in_imm = 4'd0; out_ready = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();
    check("reset_in_ready", 16'(in_ready), 16'd1);

    // ADD word then its pop advancing the address
    step(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
    check("add_word", 16'(out_im), 16'h145);
    check("add_addr0", 16'(out_addr), 16'd0);
    idle(1'b1);
    check("add_addr1", 16'(out_addr), 16'd1);

    // SHL forces c=1 and imm=0010
    step(1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0);
    check("shl_word", 16'(out_im), 16'h172);
    idle(1'b1);

    // OR aliasing a special op, then a legal immediate OR
    step(1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
    check("or_alias_err", 16'(err), LEGAL_CHECK ? 16'd1 : 16'd0);
    check("or_alias_cnt", 16'(err_cnt), LEGAL_CHECK ? 16'd1 : 16'd0);
    step(1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
    check("or_err_pulse_end", 16'(err), 16'd0);
    check("or_word", 16'(out_im), 16'h1B9);
    idle(1'b1);

    // Back-to-back requests against a stalled output
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("full_in_ready", 16'(in_ready), 16'd0);
      step(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 4'(i + 1), 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      check("drain_word", 16'(out_im), 16'(ref_word(0, 0, 0, 1, i + 1)));
      check("drain_addr", 16'(out_addr), 16'(i));
      idle(1'b1);
    end
    check("drain_empty", 16'(out_valid), 16'd0);

    // Address wrap over 17 pops, then flush racing a push
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) step(1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 4'(i), 1'b1, 1'b0);
    check("wrap_addr", 16'(out_addr), 16'd1);
    step(1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1);
    check("flush_valid", 16'(out_valid), 16'd0);
    check("flush_addr", 16'(out_addr), 16'd0);
    idle(1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) rand_step();

    // Asynchronous reset with three words queued
    step(1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_im", 16'(out_im), 16'd0);
    check("rst_err_cnt", 16'(err_cnt), 16'd0);
    check_outputs();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_in_ready", 16'(in_ready), 16'd1);
    check_outputs();
    for (int i = 0; i < 40; i++) rand_step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
